// File: rtl/hydration_pkg.sv
// Shared types and widths for the hydration reminder controller.
package hydration_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      ALERT  = 2'd2,
      SNOOZE = 2'd3
   } state_t;

   localparam int unsigned SECS_W   = 12;
   localparam int unsigned MISSED_W = 4;
   localparam logic [MISSED_W-1:0] MISSED_MAX = 4'd15;

endpackage

// File: rtl/hydration_reminder_ctrl_btn_rise_sync.sv
// Two-flop synchronizer plus registered rising-edge detector for a raw push button.
module btn_rise_sync (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic rise
);

   logic meta_q, sync_q, prev_q, rise_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         meta_q <= btn_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
         rise_q <= sync_q & ~prev_q;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/hydration_reminder_ctrl.sv
// Drink-interval timer: counts down, raises a beeping alert, handles ack/snooze/missed.
module hydration_reminder_ctrl
   import hydration_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 25000000,
   parameter int unsigned INTERVAL_SEC  = 1800,
   parameter int unsigned SNOOZE_SEC    = 300,
   parameter int unsigned ALERT_MAX_SEC = 60
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                ack_btn,
   input  logic                snooze_btn,
   output logic                reminder,
   output logic                alert,
   output logic [SECS_W-1:0]   secs_left,
   output logic [MISSED_W-1:0] missed,
   output logic [1:0]          state
);

   localparam int unsigned PRESC_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
   localparam logic [PRESC_W-1:0] PRESC_HALF = PRESC_W'(TICKS_PER_SEC / 2 - 1);
   localparam logic [SECS_W-1:0]  LOAD_INT   = SECS_W'(INTERVAL_SEC);
   localparam logic [SECS_W-1:0]  LOAD_SNZ   = SECS_W'(SNOOZE_SEC);
   localparam logic [SECS_W-1:0]  LOAD_ALRT  = SECS_W'(ALERT_MAX_SEC);
   localparam logic [SECS_W-1:0]  ONE_SEC    = SECS_W'(1);

   state_t                state_q, state_d;
   logic [PRESC_W-1:0]    presc_q, presc_d;
   logic [SECS_W-1:0]     secs_q, secs_d;
   logic [MISSED_W-1:0]   missed_q, missed_d;
   logic                  beep_q, beep_d;
   logic                  ack_rise, snooze_rise;
   logic                  sec_tick, half_tick;

   btn_rise_sync u_ack_sync (
      .clk    (clk),
      .reset  (reset),
      .btn_in (ack_btn),
      .rise   (ack_rise)
   );

   btn_rise_sync u_snooze_sync (
      .clk    (clk),
      .reset  (reset),
      .btn_in (snooze_btn),
      .rise   (snooze_rise)
   );

   assign sec_tick  = (presc_q == PRESC_LAST);
   assign half_tick = (presc_q == PRESC_HALF) || sec_tick;

   always_comb begin
      state_d  = state_q;
      secs_d   = secs_q;
      missed_d = missed_q;
      beep_d   = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         secs_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = COUNT;
               secs_d  = LOAD_INT;
            end
            COUNT: begin
               if (ack_rise) begin
                  secs_d   = LOAD_INT;
                  missed_d = '0;
               end else if (sec_tick) begin
                  if (secs_q == ONE_SEC) begin
                     state_d = ALERT;
                     secs_d  = LOAD_ALRT;
                     beep_d  = 1'b1;
                  end else begin
                     secs_d = secs_q - ONE_SEC;
                  end
               end
            end
            ALERT: begin
               beep_d = half_tick ? ~beep_q : beep_q;
               if (ack_rise) begin
                  state_d  = COUNT;
                  secs_d   = LOAD_INT;
                  missed_d = '0;
                  beep_d   = 1'b0;
               end else if (snooze_rise) begin
                  state_d = SNOOZE;
                  secs_d  = LOAD_SNZ;
                  beep_d  = 1'b0;
               end else if (sec_tick) begin
                  if (secs_q == ONE_SEC) begin
                     state_d  = COUNT;
                     secs_d   = LOAD_INT;
                     missed_d = (missed_q == MISSED_MAX) ? missed_q
                                                         : missed_q + MISSED_W'(1);
                     beep_d   = 1'b0;
                  end else begin
                     secs_d = secs_q - ONE_SEC;
                  end
               end
            end
            SNOOZE: begin
               if (ack_rise) begin
                  state_d  = COUNT;
                  secs_d   = LOAD_INT;
                  missed_d = '0;
               end else if (sec_tick) begin
                  if (secs_q == ONE_SEC) begin
                     state_d = ALERT;
                     secs_d  = LOAD_ALRT;
                     beep_d  = 1'b1;
                  end else begin
                     secs_d = secs_q - ONE_SEC;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               secs_d  = '0;
            end
         endcase
      end

      // Restart the prescaler on every phase change so each phase's first second is full.
      if ((state_d != state_q) || (state_d == IDLE)) begin
         presc_d = '0;
      end else begin
         presc_d = sec_tick ? '0 : presc_q + PRESC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         presc_q  <= '0;
         secs_q   <= '0;
         missed_q <= '0;
         beep_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         secs_q   <= secs_d;
         missed_q <= missed_d;
         beep_q   <= beep_d;
      end
   end

   assign reminder  = beep_q;
   assign alert     = (state_q == ALERT);
   assign secs_left = secs_q;
   assign missed    = missed_q;
   assign state     = state_q;

endmodule

// File: tb/tb_hydration_reminder_ctrl.sv
// Self-checking bench: directed scenarios plus randomized run against a behavioural model.
module tb_hydration_reminder_ctrl;

   localparam int T    = 4;
   localparam int INT  = 3;
   localparam int SNZ  = 2;
   localparam int AMAX = 4;

   logic        clk = 1'b0;
   logic        reset, enable, ack_btn, snooze_btn;
   logic        reminder, alert;
   logic [11:0] secs_left;
   logic [3:0]  missed;
   logic [1:0]  state;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: phase number, seconds left, missed count, cycles since phase start.
   int       m_phase, m_secs, m_missed, m_elapsed;
   bit [3:0] m_ah, m_sh;

   hydration_reminder_ctrl #(
      .TICKS_PER_SEC (T),
      .INTERVAL_SEC  (INT),
      .SNOOZE_SEC    (SNZ),
      .ALERT_MAX_SEC (AMAX)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .ack_btn    (ack_btn),
      .snooze_btn (snooze_btn),
      .reminder   (reminder),
      .alert      (alert),
      .secs_left  (secs_left),
      .missed     (missed),
      .state      (state)
   );

   initial forever #5 clk = ~clk;

   // Advances the model by one clock edge using the inputs as they stand before the edge.
   task automatic model_step();
      bit ar, sr, tick;
      int el;
      if (reset) begin
         m_phase = 0; m_secs = 0; m_missed = 0; m_elapsed = 0; m_ah = '0; m_sh = '0;
         return;
      end
      // A press is acted on three edges after it is first sampled.
      ar   = m_ah[2] & ~m_ah[3];
      sr   = m_sh[2] & ~m_sh[3];
      m_ah = {m_ah[2:0], ack_btn};
      m_sh = {m_sh[2:0], snooze_btn};
      tick = (m_elapsed % T) == T - 1;
      el   = m_elapsed + 1;
      if (!enable) begin
         m_phase = 0; m_secs = 0; el = 0;
      end else if (m_phase == 0) begin
         m_phase = 1; m_secs = INT; el = 0;
      end else if (ar) begin
         if (m_phase != 1) el = 0;
         m_phase = 1; m_secs = INT; m_missed = 0;
      end else if (sr && m_phase == 2) begin
         m_phase = 3; m_secs = SNZ; el = 0;
      end else if (tick) begin
         if (m_secs > 1) m_secs = m_secs - 1;
         else if (m_phase == 2) begin
            m_phase = 1; m_secs = INT; el = 0;
            m_missed = (m_missed < 15) ? m_missed + 1 : 15;
         end else begin
            m_phase = 2; m_secs = AMAX; el = 0;
         end
      end
      m_elapsed = el;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         model_step();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; ack_btn = 1'b0; snooze_btn = 1'b0;
      step(2);
      n_tests++;
      if ({state, secs_left, missed, reminder, alert} !== 20'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got st=%0d secs=%0d miss=%0d rem=%0b al=%0b expected all 0",
                  state, secs_left, missed, reminder, alert);
      end
      reset = 1'b0;
      step(2);
      n_tests++;
      if (state !== 2'd0) begin
         n_fail++; $display("FAIL idle_when_disabled: got %0d expected 0", state);
      end
   endtask

   task automatic test_count();
      enable = 1'b1;
      step(1);
      n_tests++;
      if (state !== 2'd1 || secs_left !== 12'd3) begin
         n_fail++; $display("FAIL count_entry: got st=%0d secs=%0d expected st=1 secs=3", state, secs_left);
      end
      step(4);
      n_tests++;
      if (secs_left !== 12'd2) begin
         n_fail++; $display("FAIL count_sec1: got %0d expected 2", secs_left);
      end
      step(4);
      n_tests++;
      if (secs_left !== 12'd1) begin
         n_fail++; $display("FAIL count_sec2: got %0d expected 1", secs_left);
      end
      step(3);
      n_tests++;
      if (state !== 2'd1) begin
         n_fail++; $display("FAIL count_not_early: got %0d expected 1", state);
      end
      step(1);
      n_tests++;
      if (state !== 2'd2 || alert !== 1'b1 || secs_left !== 12'd4 || reminder !== 1'b1) begin
         n_fail++;
         $display("FAIL alert_entry: got st=%0d al=%0b secs=%0d rem=%0b expected st=2 al=1 secs=4 rem=1",
                  state, alert, secs_left, reminder);
      end
   endtask

   task automatic test_alert_timeout();
      int bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (reminder !== (((i % 4) < 2) ? 1'b1 : 1'b0)) bad++;
         step(1);
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL beep_pattern: got %0d wrong cycles expected 0", bad);
      end
      n_tests++;
      if (state !== 2'd1 || missed !== 4'd1 || secs_left !== 12'd3) begin
         n_fail++;
         $display("FAIL timeout_missed: got st=%0d miss=%0d secs=%0d expected st=1 miss=1 secs=3",
                  state, missed, secs_left);
      end
      for (int k = 2; k <= 16; k++) begin
         step(28);
         n_tests++;
         if (missed !== 4'((k > 15) ? 15 : k) || state !== 2'd1) begin
            n_fail++;
            $display("FAIL missed_sat_%0d: got miss=%0d st=%0d expected miss=%0d st=1",
                     k, missed, state, (k > 15) ? 15 : k);
         end
      end
   endtask

   task automatic test_ack();
      step(12);
      ack_btn = 1'b1;
      step(3);
      n_tests++;
      if (state !== 2'd2) begin
         n_fail++; $display("FAIL ack_latency_early: got %0d expected 2", state);
      end
      step(1);
      n_tests++;
      if (state !== 2'd1 || missed !== 4'd0 || reminder !== 1'b0 || secs_left !== 12'd3) begin
         n_fail++;
         $display("FAIL ack_clear: got st=%0d miss=%0d rem=%0b secs=%0d expected st=1 miss=0 rem=0 secs=3",
                  state, missed, reminder, secs_left);
      end
      step(6);
      ack_btn = 1'b0;
      n_tests++;
      if (state !== 2'd1 || secs_left !== 12'd2) begin
         n_fail++; $display("FAIL ack_held_once: got st=%0d secs=%0d expected st=1 secs=2", state, secs_left);
      end
      step(6);
      n_tests++;
      if (state !== 2'd2) begin
         n_fail++; $display("FAIL realert: got %0d expected 2", state);
      end
   endtask

   task automatic test_snooze();
      snooze_btn = 1'b1;
      step(4);
      snooze_btn = 1'b0;
      n_tests++;
      if (state !== 2'd3 || secs_left !== 12'd2 || reminder !== 1'b0 || alert !== 1'b0) begin
         n_fail++;
         $display("FAIL snooze_entry: got st=%0d secs=%0d rem=%0b al=%0b expected st=3 secs=2 rem=0 al=0",
                  state, secs_left, reminder, alert);
      end
      step(8);
      n_tests++;
      if (state !== 2'd2 || secs_left !== 12'd4 || reminder !== 1'b1) begin
         n_fail++;
         $display("FAIL snooze_expiry: got st=%0d secs=%0d rem=%0b expected st=2 secs=4 rem=1",
                  state, secs_left, reminder);
      end
   endtask

   task automatic test_back_to_back();
      ack_btn = 1'b1; snooze_btn = 1'b1;
      step(4);
      ack_btn = 1'b0; snooze_btn = 1'b0;
      n_tests++;
      if (state !== 2'd1) begin
         n_fail++; $display("FAIL ack_beats_snooze: got %0d expected 1", state);
      end
      step(12);
      snooze_btn = 1'b1;
      step(4);
      snooze_btn = 1'b0;
      n_tests++;
      if (state !== 2'd3) begin
         n_fail++; $display("FAIL snooze_again: got %0d expected 3", state);
      end
      enable = 1'b0;
      step(1);
      n_tests++;
      if (state !== 2'd0 || secs_left !== 12'd0 || reminder !== 1'b0 || alert !== 1'b0) begin
         n_fail++;
         $display("FAIL disable_snooze: got st=%0d secs=%0d expected st=0 secs=0", state, secs_left);
      end
   endtask

   task automatic test_reset_mid();
      enable = 1'b1;
      step(1 + 3 * 28 + 12);
      n_tests++;
      if (state !== 2'd2 || missed !== 4'd3) begin
         n_fail++; $display("FAIL pre_reset: got st=%0d miss=%0d expected st=2 miss=3", state, missed);
      end
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      n_tests++;
      if ({state, secs_left, missed, reminder, alert} !== 20'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got st=%0d secs=%0d miss=%0d rem=%0b al=%0b expected all 0",
                  state, secs_left, missed, reminder, alert);
      end
      step(1);
      n_tests++;
      if (state !== 2'd1 || secs_left !== 12'd3) begin
         n_fail++; $display("FAIL post_reset: got st=%0d secs=%0d expected st=1 secs=3", state, secs_left);
      end
   endtask

   task automatic test_random();
      logic [19:0] got, exp;
      int bad = 0;
      for (int c = 0; c < 4000; c++) begin
         reset  = ($urandom_range(0, 399) == 0);
         enable = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 29) == 0) ack_btn = ~ack_btn;
         if ($urandom_range(0, 9) == 0) snooze_btn = ~snooze_btn;
         step(1);
         exp = {2'(m_phase), 12'(m_secs), 4'(m_missed), (m_phase == 2),
                (m_phase == 2) && ((m_elapsed % T) < T / 2)};
         got = {state, secs_left, missed, alert, reminder};
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            if (bad < 10)
               $display("FAIL random_cycle_%0d: got %h expected %h", c, got, exp);
            bad++;
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count();
      test_alert_timeout();
      test_ack();
      test_snooze();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hydration_reminder_ctrl.md
Name: hydration_reminder_ctrl

Overview:
Reminder-generation FSM. Produces the `reminder` level that gates the buzzer, plus status for the VGA text overlay. Counts a drink interval, then raises an alert that beeps with a 50% duty cycle. The alert is cleared by a "drank" acknowledge button, deferred by a snooze button, and counted as missed on timeout. Sits between the board buttons/switch and the audio and display blocks.

Parameters:
TICKS_PER_SEC, 25000000, clk cycles per second (25 MHz pixel clock); must be even and ≥2
INTERVAL_SEC, 1800, seconds from start of COUNT to ALERT; range 1..4095
SNOOZE_SEC, 300, snooze duration in seconds; range 1..4095
ALERT_MAX_SEC, 60, unacknowledged ALERT duration before it is logged as missed; range 1..4095

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  slide switch; 0 forces IDLE
ack_btn  in  1  raw "drank" push button, asynchronous to clk
snooze_btn  in  1  raw snooze push button, asynchronous to clk
reminder  out  1  beep-gated alert level, drives the audio block
alert  out  1  steady 1 while in ALERT
secs_left  out  12  seconds remaining in the current COUNT, SNOOZE or ALERT phase
missed  out  4  consecutive missed alerts, saturating at 15
state  out  2  IDLE=0, COUNT=1, ALERT=2, SNOOZE=3

Behaviour:
- Reset: state=IDLE, prescaler=0, secs_left=0, missed=0, beep_phase=0, reminder=0, alert=0, synchronizers=0.
- Button path: 2-flop synchronizer, then rising-edge detect. A press is seen as a 1-cycle `*_rise` pulse 3 clk edges after the input rises. The FSM acts on it at the next edge. Held buttons produce one pulse only.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1.
  - sec_tick = 1 when it equals TICKS_PER_SEC-1 (then it wraps to 0).
  - half_tick = 1 when it equals TICKS_PER_SEC/2-1 or TICKS_PER_SEC-1.
  - Cleared to 0 on every state change, so each phase's first second is full length.
  - Held at 0 in IDLE.
- IDLE: when enable=1, go to COUNT at the next edge and load secs_left=INTERVAL_SEC.
- COUNT:
  - sec_tick decrements secs_left.
  - sec_tick with secs_left==1 → ALERT: secs_left=ALERT_MAX_SEC, beep_phase=1.
  - ack_rise → reload secs_left=INTERVAL_SEC (early drink, stay in COUNT); missed cleared.
  - snooze_rise ignored.
- ALERT:
  - alert=1.
  - beep_phase toggles on each half_tick.
  - reminder = beep_phase, registered, so it goes high on the same edge that enters ALERT.
  - sec_tick decrements secs_left.
  - ack_rise → COUNT: secs_left=INTERVAL_SEC, missed=0.
  - snooze_rise → SNOOZE: secs_left=SNOOZE_SEC.
  - sec_tick with secs_left==1 → COUNT: secs_left=INTERVAL_SEC, missed=min(missed+1,15).
- SNOOZE:
  - reminder=0, alert=0.
  - sec_tick decrements secs_left.
  - Expiry (sec_tick with secs_left==1) → ALERT: same load as entry from COUNT.
  - ack_rise → COUNT: secs_left=INTERVAL_SEC, missed=0.
  - snooze_rise ignored (no stacking).
- Priority within a cycle: enable=0 > ack_rise > snooze_rise > timer expiry.
  - ack coinciding with ALERT timeout counts as acked: missed=0.
- enable=0 from any state: next edge → IDLE, reminder=0, alert=0, secs_left=0; missed is retained.
- reset mid-operation: all registers return to their reset values at the next edge regardless of state or button activity.
- secs_left never underflows: 0 only in IDLE. reminder and alert are 0 in every state except ALERT.

Decomposition:
- Package hydration_pkg:
  - state_t enum (IDLE, COUNT, ALERT, SNOOZE; 2-bit encoding as in Ports).
  - SECS_W=12 and MISSED_W=4 constants.
  - MISSED_MAX=15.
- Sub-module btn_rise_sync (clk, reset, btn_in → rise): 2-flop sync plus edge detector, instantiated for ack and snooze.

Test Plan:
(All scenarios use TICKS_PER_SEC=4, INTERVAL_SEC=3, SNOOZE_SEC=2, ALERT_MAX_SEC=4.)
- Reset then enable=1 → state=1 next edge, secs_left=3; reaches 2,1 at 4-cycle spacing; state=2 exactly 12 cycles after entering COUNT; alert=1, secs_left=4.
- In ALERT, no buttons → reminder pattern 1,1,0,0 repeating; after 16 cycles state=1, missed=1, secs_left=3. Repeat 16 times → missed saturates at 15.
- In ALERT, pulse ack_btn for 10 cycles → exactly one ack_rise; state=1 four edges after the button rises; missed=0; reminder=0.
- In ALERT, press snooze → state=3, secs_left=2, reminder=0; after 8 cycles state=2, secs_left=4, reminder=1.
- In ALERT, ack_btn and snooze_btn rise in the same cycle → state=1 (ack wins). Separately, drop enable in SNOOZE → state=0, secs_left=0 next edge.
- Assert reset for 1 cycle during ALERT with missed=3 → all outputs 0, state=0. With enable still 1, state=1 and secs_left=3 one edge later.
